// File: rtl/io_port_controller.sv
// io_port_controller: CPU I/O port decoder (inputs, shifter, sound latches); watchdog under VERINVADERS_WATCHDOG_EN
module io_port_controller #(
  parameter logic [7:0] WDT_MAX = 8'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_req,
  input  logic       io_we,
  input  logic [7:0] io_port,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       io_ack,
  input  logic [7:0] inp0,
  input  logic [7:0] inp1,
  input  logic [7:0] inp2,
  output logic [7:0] shift_wdata,
  output logic       shift_wenable,
  output logic [2:0] shift_amount,
  input  logic [7:0] shift_result,
  output logic [7:0] snd1,
  output logic [7:0] snd2,
  output logic [7:0] snd1_rise,
  output logic [7:0] snd2_rise,
  input  logic       wdt_tick,
  output logic       wdt_expire
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;
  state_t state_q, state_d;
  logic [7:0] rdata_q, rdata_d, swd_q, swd_d, snd1_q, snd1_d, snd2_q, snd2_d;
  logic [7:0] rise1_q, rise1_d, rise2_q, rise2_d, in_data;
  logic [2:0] amt_q, amt_d;
  logic       ack_q, ack_d, swen_q, swen_d, commit, wr;
  assign commit  = state_q == ACCESS;
  assign wr      = commit && io_we;
  assign in_data = (io_port == 8'd0) ? inp0 :
                   (io_port == 8'd1) ? inp1 :
                   (io_port == 8'd2) ? inp2 :
                   (io_port == 8'd3) ? shift_result : 8'h00;
  // handshake sequencing: one access per io_req assertion, wait for release
  always_comb begin
    state_d = (state_q == IDLE)   ? (io_req ? ACCESS : IDLE) :
              (state_q == ACCESS) ? ACK :
              (state_q == ACK)    ? RELEASE :
              (io_req ? RELEASE : IDLE);
  end
  // side effects commit on the edge leaving ACCESS so they show during ACK
  always_comb begin
    ack_d   = commit;
    rdata_d = (commit && !io_we) ? in_data : rdata_q;
    amt_d   = (wr && io_port == 8'd2) ? io_wdata[2:0] : amt_q;
    snd1_d  = (wr && io_port == 8'd3) ? io_wdata : snd1_q;
    rise1_d = (wr && io_port == 8'd3) ? (io_wdata & ~snd1_q) : 8'h00;
    swd_d   = (wr && io_port == 8'd4) ? io_wdata : swd_q;
    swen_d  = wr && io_port == 8'd4;
    snd2_d  = (wr && io_port == 8'd5) ? io_wdata : snd2_q;
    rise2_d = (wr && io_port == 8'd5) ? (io_wdata & ~snd2_q) : 8'h00;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
      amt_q   <= 3'd0;
      snd1_q  <= 8'h00;
      rise1_q <= 8'h00;
      swd_q   <= 8'h00;
      swen_q  <= 1'b0;
      snd2_q  <= 8'h00;
      rise2_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      amt_q   <= amt_d;
      snd1_q  <= snd1_d;
      rise1_q <= rise1_d;
      swd_q   <= swd_d;
      swen_q  <= swen_d;
      snd2_q  <= snd2_d;
      rise2_q <= rise2_d;
    end
  end
  assign io_ack        = ack_q;
  assign io_rdata      = rdata_q;
  assign shift_amount  = amt_q;
  assign shift_wdata   = swd_q;
  assign shift_wenable = swen_q;
  assign snd1          = snd1_q;
  assign snd2          = snd2_q;
  assign snd1_rise     = rise1_q;
  assign snd2_rise     = rise2_q;
`ifdef VERINVADERS_WATCHDOG_EN
  logic [7:0] cnt_q, cnt_d;
  logic       exp_q, exp_d, kick;
  assign kick = wr && io_port == 8'd6;
  // a kick beats a coincident tick; expiry restarts the count
  always_comb begin
    exp_d = !kick && wdt_tick && cnt_q == WDT_MAX - 8'd1;
    cnt_d = (kick || exp_d) ? 8'd0 : wdt_tick ? cnt_q + 8'd1 : cnt_q;
  end
  // watchdog counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end
  assign wdt_expire = exp_q;
`else
  logic unused_wdt;
  assign unused_wdt = wdt_tick ^ (WDT_MAX == 8'd0);
  assign wdt_expire = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: scoreboard bench for io_port_controller (watchdog tests when VERINVADERS_WATCHDOG_EN set)
module tb_io_port_controller;
  logic clk = 0, rst = 0, io_req = 0, io_we = 0, wdt_tick = 0;
  logic [7:0] io_port = 0, io_wdata = 0, inp0 = 8'h11, inp1 = 8'h00, inp2 = 8'h22, shift_result = 8'h00;
  logic [7:0] io_rdata, shift_wdata, snd1, snd2, snd1_rise, snd2_rise;
  logic [2:0] shift_amount;
  logic io_ack, shift_wenable, wdt_expire;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] rdata; logic [7:0] rise1; logic [7:0] rise2; logic wen;} exp_t;
  exp_t sb[$];
  logic [7:0] m_rdata = 0, m_swd = 0, m_snd1 = 0, m_snd2 = 0;
  logic [2:0] m_amt = 0;

  io_port_controller #(.WDT_MAX(8'd4)) dut (
    .clk(clk), .rst(rst), .io_req(io_req), .io_we(io_we), .io_port(io_port), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .inp0(inp0), .inp1(inp1), .inp2(inp2),
    .shift_wdata(shift_wdata), .shift_wenable(shift_wenable), .shift_amount(shift_amount),
    .shift_result(shift_result), .snd1(snd1), .snd2(snd2), .snd1_rise(snd1_rise), .snd2_rise(snd2_rise),
    .wdt_tick(wdt_tick), .wdt_expire(wdt_expire)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_in(input logic [7:0] p);
    return (p == 8'd0) ? inp0 : (p == 8'd1) ? inp1 : (p == 8'd2) ? inp2 : (p == 8'd3) ? shift_result : 8'h00;
  endfunction

  task automatic push_exp(input logic we, input logic [7:0] port, input logic [7:0] data);
    exp_t e;
    e.wen   = we && port == 8'd4;
    e.rise1 = (we && port == 8'd3) ? (data & ~m_snd1) : 8'h00;
    e.rise2 = (we && port == 8'd5) ? (data & ~m_snd2) : 8'h00;
    if (we) begin
      if (port == 8'd2) m_amt = data[2:0];
      if (port == 8'd3) m_snd1 = data;
      if (port == 8'd4) m_swd = data;
      if (port == 8'd5) m_snd2 = data;
    end else m_rdata = model_in(port);
    e.rdata = m_rdata;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard empty at io_ack", tag);
      return;
    end
    e = sb.pop_front();
    if (io_rdata !== e.rdata || snd1_rise !== e.rise1 || snd2_rise !== e.rise2 || shift_wenable !== e.wen) begin
      errors++;
      $display("FAIL %s ack outputs: rdata=%h rise1=%h rise2=%h wen=%b, want rdata=%h rise1=%h rise2=%h wen=%b",
               tag, io_rdata, snd1_rise, snd2_rise, shift_wenable, e.rdata, e.rise1, e.rise2, e.wen);
    end
  endtask

  task automatic check_state(input string tag);
    checks++;
    if ({shift_wdata, shift_amount, snd1, snd2, io_rdata} !== {m_swd, m_amt, m_snd1, m_snd2, m_rdata}) begin
      errors++;
      $display("FAIL %s held: swd=%h amt=%h snd1=%h snd2=%h rdata=%h, want %h %h %h %h %h", tag,
               shift_wdata, shift_amount, snd1, snd2, io_rdata, m_swd, m_amt, m_snd1, m_snd2, m_rdata);
    end
  endtask

  task automatic access(input logic we, input logic [7:0] port, input logic [7:0] data, input string tag);
    int n = 0;
    logic got = 0, early = 0;
    push_exp(we, port, data);
    io_we = we; io_port = port; io_wdata = data; io_req = 1;
    while (!got && n < 16) begin
      @(negedge clk); n++;
      got = io_ack;
      if (!got && (shift_wenable || |snd1_rise || |snd2_rise)) early = 1;
    end
    checks++;
    if (!got || n != 2 || early) begin
      errors++; $display("FAIL %s latency: acked=%b after %0d cycles early_pulse=%b, want ack after 2", tag, got, n, early);
    end
    if (got) pop_cmp(tag); else void'(sb.pop_front());
    io_req = 0;
    @(negedge clk);
    checks++;
    if (io_ack || shift_wenable || |snd1_rise || |snd2_rise) begin
      errors++; $display("FAIL %s pulse width: ack=%b wen=%b rise1=%h rise2=%h, want all 0", tag, io_ack, shift_wenable, snd1_rise, snd2_rise);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({io_rdata, io_ack, shift_wdata, shift_wenable, shift_amount, snd1, snd2, snd1_rise, snd2_rise, wdt_expire} !== '0) begin
      errors++; $display("FAIL reset outputs: rdata=%h ack=%b swd=%h wen=%b amt=%h snd1=%h snd2=%h, want 0",
                         io_rdata, io_ack, shift_wdata, shift_wenable, shift_amount, snd1, snd2);
    end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_shift_write;
    access(1, 8'd4, 8'hA5, "out4_a5");
  endtask

  task automatic test_shift_read;
    access(1, 8'd2, 8'hFB, "out2_fb");
    shift_result = 8'h3C;
    access(0, 8'd3, 8'h00, "in3_shift");
    access(0, 8'd0, 8'h00, "in0");
    access(0, 8'd2, 8'h00, "in2");
  endtask

  task automatic test_sound;
    access(1, 8'd3, 8'h05, "out3_05");
    access(1, 8'd3, 8'h0C, "out3_0c");
    access(1, 8'd5, 8'h81, "out5_81");
    access(1, 8'd5, 8'h03, "out5_03");
    access(1, 8'd7, 8'h77, "out7_none");
  endtask

  task automatic test_held_req;
    int acks = 0;
    inp1 = 8'h81;
    push_exp(0, 8'd1, 8'h00);
    io_we = 0; io_port = 8'd1; io_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io_ack) begin acks++; pop_cmp("held_in1"); end
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL held_in1 ack count: %0d, want 1", acks); end
    io_req = 0;
    repeat (2) @(negedge clk);
    access(0, 8'd9, 8'h00, "in9_zero");
  endtask

  task automatic test_reset_mid;
    int acks = 0, lat = 0, n = 0;
    io_we = 1; io_port = 8'd5; io_wdata = 8'hFF; io_req = 1;
    @(negedge clk);
    rst = 0;
    m_rdata = 0; m_swd = 0; m_amt = 0; m_snd1 = 0; m_snd2 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (io_ack || snd2 !== 8'h00) begin errors++; $display("FAIL rst_mid during reset: ack=%b snd2=%h, want 0 0", io_ack, snd2); end
    end
    check_state("rst_mid_clear");
    push_exp(1, 8'd5, 8'hFF);
    rst = 1;
    while (n < 8) begin
      @(negedge clk); n++;
      if (io_ack) begin acks++; lat = n; pop_cmp("rst_mid_retry"); end
    end
    checks++;
    if (acks != 1 || lat != 2) begin errors++; $display("FAIL rst_mid retry: %0d acks at cycle %0d, want 1 at 2", acks, lat); end
    io_req = 0;
    repeat (2) @(negedge clk);
    check_state("rst_mid_after");
  endtask

  task automatic tick(output logic at, output logic after);
    wdt_tick = 1;
    @(negedge clk);
    at = wdt_expire;
    wdt_tick = 0;
    @(negedge clk);
    after = wdt_expire;
  endtask

  task automatic test_watchdog;
    logic a, b;
`ifdef VERINVADERS_WATCHDOG_EN
    for (int i = 0; i < 4; i++) begin
      tick(a, b);
      checks++;
      if (a !== (i == 3) || b !== 1'b0) begin errors++; $display("FAIL wdt tick %0d: expire=%b next=%b, want %b 0", i + 1, a, b, i == 3); end
    end
    for (int i = 0; i < 3; i++) tick(a, b);
    push_exp(1, 8'd6, 8'h00);
    io_we = 1; io_port = 8'd6; io_wdata = 8'h00; io_req = 1;
    @(negedge clk);
    wdt_tick = 1;
    @(negedge clk);
    wdt_tick = 0;
    if (io_ack) pop_cmp("kick_ack"); else void'(sb.pop_front());
    checks++;
    if (io_ack !== 1'b1 || wdt_expire !== 1'b0) begin errors++; $display("FAIL wdt kick+tick: ack=%b expire=%b, want 1 0", io_ack, wdt_expire); end
    io_req = 0;
    @(negedge clk);
    checks++;
    if (wdt_expire !== 1'b0) begin errors++; $display("FAIL wdt kick+tick late expire=%b, want 0", wdt_expire); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick(a, b);
      checks++;
      if (a !== (i == 3)) begin errors++; $display("FAIL wdt after kick tick %0d: expire=%b, want %b", i + 1, a, i == 3); end
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick(a, b);
      checks++;
      if (a !== 1'b0 || b !== 1'b0) begin errors++; $display("FAIL wdt disabled tick %0d: expire=%b/%b, want 0", i + 1, a, b); end
    end
    access(1, 8'd6, 8'h00, "out6_noeffect");
`endif
  endtask

  initial begin
    test_reset;
    test_shift_write;
    test_shift_read;
    test_sound;
    test_held_req;
    test_reset_mid;
    test_watchdog;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
